// File: rtl/usb_pkg.sv
// usb_pkg: shared USB receive-path definitions.
// Holds the decoded packet class, PID codes, CRC polynomials/init/residuals
// and the fixed packet lengths (in bits, PID included).
package usb_pkg;

  // Values match the `TOKEN / DATA / HSHAKE encodings used by the host FSM.
  typedef enum logic [1:0] {
    PktNone   = 2'b00,
    PktToken  = 2'b01,
    PktData   = 2'b10,
    PktHshake = 2'b11
  } pkt_type_t;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

  localparam logic [15:0] Crc16Poly  = 16'h8005;
  localparam logic [15:0] Crc16Init  = 16'hFFFF;
  localparam logic [15:0] Crc16Resid = 16'h800D;
  localparam logic [4:0]  Crc5Poly   = 5'b00101;
  localparam logic [4:0]  Crc5Init   = 5'b11111;
  localparam logic [4:0]  Crc5Resid  = 5'b01100;

  localparam logic [6:0] LenHshake  = 7'd8;
  localparam logic [6:0] LenToken   = 7'd24;
  localparam logic [6:0] LenData    = 7'd88;
  localparam logic [6:0] PayloadEnd = 7'd72;  // first bit index past the 64-bit payload
  localparam logic [6:0] TokenEnd   = 7'd19;  // first bit index past the 11 token bits

endpackage

// File: rtl/rc_crc_lfsr.sv
// rc_crc_lfsr: serial CRC register, MSB feedback.
//   clk, rst : clock, synchronous active-high reset (loads Init)
//   clr      : reload Init (wins over en)
//   en       : shift in one bit from din
//   din      : serial data bit
//   crc      : current register contents
module rc_crc_lfsr #(
  parameter int unsigned     Width = 16,
  parameter logic [Width-1:0] Poly = '0,
  parameter logic [Width-1:0] Init = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [Width-1:0] crc
);

  logic [Width-1:0] crc_q, crc_d;
  logic             fb;

  always_comb begin
    fb    = din ^ crc_q[Width-1];
    crc_d = crc_q;
    if (clr) begin
      crc_d = Init;
    end else if (en) begin
      crc_d = {crc_q[Width-2:0], 1'b0} ^ (fb ? Poly : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= Init;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/rc_pkt_check.sv
// rc_pkt_check: receive-side USB packet checker (after the bit unstuffer).
// Captures/validates the PID, assembles the payload, checks the CRC residual
// and reports the decoded packet with error flags for one cycle on done.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   s_in                          : unstuffed serial bit, LSB first
//   start_decode, end_decode      : packet start / EOP pulses
//   bitUnstuff_wait               : s_in invalid this cycle (stuffed bit)
//   abort                         : drop the packet in progress, no report
//   receive_data, receive_hshake  : packet class the host expects
//   busy, done                    : packet in progress / result valid pulse
//   pkt_type, pid, data, token    : decoded result (held until next report)
//   pid_error, crc_error, len_error : status flags, valid with done
// Build option: define RC_TOKEN_RX_EN to accept token packets (CRC5 check);
// otherwise token PIDs are PID errors and token is tied to zero.
module rc_pkt_check
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_in,
  input  logic        start_decode,
  input  logic        end_decode,
  input  logic        bitUnstuff_wait,
  input  logic        abort,
  input  logic        receive_data,
  input  logic        receive_hshake,
  output logic        busy,
  output logic        done,
  output logic [1:0]  pkt_type,
  output logic [3:0]  pid,
  output logic [63:0] data,
  output logic [10:0] token,
  output logic        pid_error,
  output logic        crc_error,
  output logic        len_error
);

  typedef enum logic [2:0] {
    StIdle, StPid, StData, StHsk, StTok, StDrain, StReport
  } state_t;

  state_t      state_q, state_d, pid_next;
  logic [6:0]  bit_cnt_q;
  logic [7:0]  pid_sr_q;
  logic [3:0]  pid_cap_q;
  logic        pid_err_q;
  logic [63:0] data_sr_q;
  logic [7:0]  pid_byte;
  logic [5:0]  pay_idx;
  logic        abort_go, start_go, in_pkt, finish, consume, last_pid_bit;
  logic        crc16_en;
  logic [15:0] crc16;

  pkt_type_t   pkt_type_q, pkt_type_d;
  logic [3:0]  pid_q;
  logic [63:0] data_q;
  logic [10:0] token_q, token_d;
  logic        pid_error_q, crc_error_q, crc_error_d, len_error_q, len_error_d;

  always_comb begin
    abort_go     = abort && (state_q != StIdle);
    start_go     = start_decode && !abort_go;
    in_pkt       = state_q inside {StPid, StData, StHsk, StTok, StDrain};
    finish       = in_pkt && end_decode && !abort_go && !start_go;
    consume      = in_pkt && !bitUnstuff_wait && !end_decode && !abort_go && !start_go;
    last_pid_bit = consume && (state_q == StPid) && (bit_cnt_q == 7'd7);
    pid_byte     = {s_in, pid_sr_q[7:1]};
    pay_idx      = 6'(bit_cnt_q - LenHshake);
    crc16_en     = consume && (state_q == StData) && (bit_cnt_q < LenData);
  end

  // PID decode: both a malformed PID and a well-formed but unexpected one drain.
  always_comb begin
    pid_next = StDrain;
    if (pid_byte[7:4] == ~pid_byte[3:0]) begin
      case (pid_byte[3:0])
        PidData0, PidData1:      if (receive_data)   pid_next = StData;
        PidAck, PidNak, PidStall: if (receive_hshake) pid_next = StHsk;
`ifdef RC_TOKEN_RX_EN
        PidOut, PidIn, PidSetup: pid_next = StTok;
`endif
        default:                 pid_next = StDrain;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_go) begin
      state_d = StIdle;
    end else if (start_go) begin
      state_d = StPid;
    end else if (finish) begin
      state_d = StReport;
    end else begin
      case (state_q)
        StPid:    if (last_pid_bit) state_d = pid_next;
        StReport: state_d = StIdle;
        default:  state_d = state_q;
      endcase
    end
  end

  rc_crc_lfsr #(
    .Width(16),
    .Poly (Crc16Poly),
    .Init (Crc16Init)
  ) u_crc16 (
    .clk(clk),
    .rst(rst),
    .clr(start_go),
    .en (crc16_en),
    .din(s_in),
    .crc(crc16)
  );

`ifdef RC_TOKEN_RX_EN
  logic [10:0] tok_sr_q;
  logic [4:0]  crc5;
  logic [3:0]  tok_idx;
  logic        crc5_en;

  assign tok_idx = 4'(bit_cnt_q - LenHshake);
  assign crc5_en = consume && (state_q == StTok) && (bit_cnt_q < LenToken);

  rc_crc_lfsr #(
    .Width(5),
    .Poly (Crc5Poly),
    .Init (Crc5Init)
  ) u_crc5 (
    .clk(clk),
    .rst(rst),
    .clr(start_go),
    .en (crc5_en),
    .din(s_in),
    .crc(crc5)
  );

  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      tok_sr_q <= '0;
    end else if (consume && (state_q == StTok) && (bit_cnt_q < TokenEnd)) begin
      tok_sr_q[tok_idx] <= s_in;
    end
  end
`endif

  // Result fields, latched on the end_decode cycle so they are stable during done.
  always_comb begin
    pkt_type_d  = PktNone;
    crc_error_d = 1'b0;
    len_error_d = 1'b0;
    token_d     = '0;
    case (state_q)
      StPid: len_error_d = 1'b1;
      StData: begin
        pkt_type_d  = PktData;
        len_error_d = (bit_cnt_q != LenData);
        crc_error_d = (crc16 != Crc16Resid);
      end
      StHsk: begin
        pkt_type_d  = PktHshake;
        len_error_d = (bit_cnt_q != LenHshake);  // any extra bit lengthens the packet
      end
`ifdef RC_TOKEN_RX_EN
      StTok: begin
        pkt_type_d  = PktToken;
        len_error_d = (bit_cnt_q != LenToken);
        crc_error_d = (crc5 != Crc5Resid);
      end
`endif
      default: pkt_type_d = PktNone;
    endcase
`ifdef RC_TOKEN_RX_EN
    token_d = tok_sr_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      pid_sr_q  <= '0;
      pid_cap_q <= '0;
      pid_err_q <= 1'b0;
      data_sr_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        bit_cnt_q <= '0;
        pid_sr_q  <= '0;
        pid_cap_q <= '0;
        pid_err_q <= 1'b0;
        data_sr_q <= '0;
      end else if (consume) begin
        if (bit_cnt_q != 7'd127) bit_cnt_q <= bit_cnt_q + 7'd1;
        if (state_q == StPid) pid_sr_q <= pid_byte;
        if (last_pid_bit) begin
          pid_cap_q <= pid_byte[3:0];
          pid_err_q <= (pid_next == StDrain);
        end
        if ((state_q == StData) && (bit_cnt_q < PayloadEnd)) data_sr_q[pay_idx] <= s_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_type_q  <= PktNone;
      pid_q       <= '0;
      data_q      <= '0;
      token_q     <= '0;
      pid_error_q <= 1'b0;
      crc_error_q <= 1'b0;
      len_error_q <= 1'b0;
    end else if (finish) begin
      pkt_type_q  <= pkt_type_d;
      pid_q       <= pid_cap_q;
      data_q      <= data_sr_q;
      token_q     <= token_d;
      pid_error_q <= pid_err_q;
      crc_error_q <= crc_error_d;
      len_error_q <= len_error_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StReport);
  assign pkt_type  = pkt_type_q;
  assign pid       = pid_q;
  assign data      = data_q;
  assign token     = token_q;
  assign pid_error = pid_error_q;
  assign crc_error = crc_error_q;
  assign len_error = len_error_q;

endmodule

// File: tb/tb_rc_pkt_check.sv
// tb_rc_pkt_check: directed stimulus with a scoreboard queue; a monitor pops
// the expected result whenever the DUT raises done.
module tb_rc_pkt_check;

  logic        clk = 1'b0;
  logic        rst, s_in, start_decode, end_decode, bitUnstuff_wait, abort;
  logic        receive_data, receive_hshake;
  logic        busy, done, pid_error, crc_error, len_error;
  logic [1:0]  pkt_type;
  logic [3:0]  pid;
  logic [63:0] data;
  logic [10:0] token;

  rc_pkt_check dut (
    .clk            (clk),
    .rst            (rst),
    .s_in           (s_in),
    .start_decode   (start_decode),
    .end_decode     (end_decode),
    .bitUnstuff_wait(bitUnstuff_wait),
    .abort          (abort),
    .receive_data   (receive_data),
    .receive_hshake (receive_hshake),
    .busy           (busy),
    .done           (done),
    .pkt_type       (pkt_type),
    .pid            (pid),
    .data           (data),
    .token          (token),
    .pid_error      (pid_error),
    .crc_error      (crc_error),
    .len_error      (len_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pt;
    logic [3:0]  pid;
    logic [63:0] data;
    logic [10:0] token;
    logic        pe, ce, le, cdc;  // cdc: crc_error not checked
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, last_e;
  int   n_vec = 0, n_err = 0, cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        check("done_width", 64'(prev_done), 64'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1, expected none at cycle %0d", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("pkt_type", 64'(pkt_type), 64'(mon_e.pt));
          check("pid", 64'(pid), 64'(mon_e.pid));
          check("data", data, mon_e.data);
          check("token", 64'(token), 64'(mon_e.token));
          check("pid_error", 64'(pid_error), 64'(mon_e.pe));
          check("len_error", 64'(len_error), 64'(mon_e.le));
          if (!mon_e.cdc) check("crc_error", 64'(crc_error), 64'(mon_e.ce));
        end
      end
      prev_done = done;
    end
  end

  function automatic exp_t mk(input logic [1:0] pt, input logic [3:0] p, input logic [63:0] d,
                              input logic [10:0] t, input logic pe, input logic ce,
                              input logic le, input logic cdc);
    exp_t e;
    e.pt = pt; e.pid = p; e.data = d; e.token = t;
    e.pe = pe; e.ce = ce; e.le = le; e.cdc = cdc; e.cyc = 0;
    return e;
  endfunction

  // Transmitter-side framing: payload LSB first, then inverted CRC MSB first.
  function automatic logic [127:0] data_pkt(input logic [7:0] pb, input logic [63:0] pay);
    logic [127:0] b;
    logic [15:0]  r;
    logic         fb;
    b = '0; b[7:0] = pb; b[71:8] = pay; r = 16'hFFFF;
    for (int i = 0; i < 64; i++) begin
      fb = pay[i] ^ r[15];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    for (int i = 0; i < 16; i++) b[72+i] = ~r[15-i];
    return b;
  endfunction

  function automatic logic [127:0] tok_pkt(input logic [7:0] pb, input logic [10:0] t);
    logic [127:0] b;
    logic [4:0]   r;
    logic         fb;
    b = '0; b[7:0] = pb; b[18:8] = t; r = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      fb = t[i] ^ r[4];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    for (int i = 0; i < 5; i++) b[19+i] = ~r[4-i];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt();
    start_decode = 1'b1;
    tick();
    start_decode = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic send_bits(input logic [127:0] bits, input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          bitUnstuff_wait = 1'b1;
          s_in = 1'($urandom_range(0, 1));
          tick();
        end
      end
      bitUnstuff_wait = 1'b0;
      s_in = bits[i];
      tick();
    end
    s_in = 1'b0;
  endtask

  task automatic end_pkt(input exp_t e);
    end_decode = 1'b1;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    last_e = e;
    tick();
    end_decode = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done, expected %0d pending", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  logic [127:0] bits;
  logic [63:0]  pay;

  initial begin
    rst = 1'b1; s_in = 1'b0; start_decode = 1'b0; end_decode = 1'b0;
    bitUnstuff_wait = 1'b0; abort = 1'b0; receive_data = 1'b1; receive_hshake = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pkt_type", 64'(pkt_type), 64'd0);
    check("rst_pid", 64'(pid), 64'd0);
    check("rst_data", data, 64'd0);
    check("rst_token", 64'(token), 64'd0);
    check("rst_flags", 64'({pid_error, crc_error, len_error}), 64'd0);

    // Good DATA0
    pay  = 64'h7ffe_0000_0000_0000;
    bits = data_pkt(8'hC3, pay);
    start_pkt(); send_bits(bits, 88, 1'b0);
    end_pkt(mk(2'b10, 4'b0011, pay, 11'h0, 1'b0, 1'b0, 1'b0, 1'b0)); drain();

    // Payload bit 20 corrupted
    bits[28] = ~bits[28];
    start_pkt(); send_bits(bits, 88, 1'b0);
    end_pkt(mk(2'b10, 4'b0011, 64'h7ffe_0000_0010_0000, 11'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    drain();

    // ACK
    bits = '0; bits[7:0] = 8'hD2;
    start_pkt(); send_bits(bits, 8, 1'b0);
    end_pkt(mk(2'b11, 4'b0010, 64'd0, 11'h0, 1'b0, 1'b0, 1'b0, 1'b0)); drain();

    // Malformed PID check field
    bits[7:0] = 8'hF2;
    start_pkt(); send_bits(bits, 8, 1'b0);
    end_pkt(mk(2'b00, 4'b0010, 64'd0, 11'h0, 1'b1, 1'b0, 1'b0, 1'b0)); drain();

    // ACK with one extra bit
    bits[7:0] = 8'hD2;
    start_pkt(); send_bits(bits, 9, 1'b0);
    end_pkt(mk(2'b11, 4'b0010, 64'd0, 11'h0, 1'b0, 1'b0, 1'b1, 1'b0)); drain();

    // DATA0 cut after 40 payload bits
    bits = data_pkt(8'hC3, 64'h0000_00A5_5A3C_C3F0);
    start_pkt(); send_bits(bits, 48, 1'b0);
    end_pkt(mk(2'b10, 4'b0011, 64'h0000_00A5_5A3C_C3F0, 11'h0, 1'b0, 1'b0, 1'b1, 1'b1));
    drain();

    // Good DATA0 with random stuffing stalls
    bits = data_pkt(8'hC3, pay);
    start_pkt(); send_bits(bits, 88, 1'b1);
    end_pkt(mk(2'b10, 4'b0011, pay, 11'h0, 1'b0, 1'b0, 1'b0, 1'b0)); drain();

    // Abort at payload bit 30: no report, outputs hold
    bits = data_pkt(8'hC3, 64'h1234_5678_9ABC_DEF0);
    start_pkt(); send_bits(bits, 38, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("busy_after_abort", 64'(busy), 64'd0);
    repeat (3) tick();
    check("hold_pkt_type", 64'(pkt_type), 64'(last_e.pt));
    check("hold_pid", 64'(pid), 64'(last_e.pid));
    check("hold_data", data, last_e.data);
    check("hold_flags", 64'({pid_error, crc_error, len_error}), 64'd0);

    // ACK after abort
    bits = '0; bits[7:0] = 8'hD2;
    start_pkt(); send_bits(bits, 8, 1'b0);
    end_pkt(mk(2'b11, 4'b0010, 64'd0, 11'h0, 1'b0, 1'b0, 1'b0, 1'b0)); drain();

    // Restart mid-packet: only the second (NAK) packet is reported
    bits = data_pkt(8'hC3, pay);
    start_pkt(); send_bits(bits, 18, 1'b0);
    bits = '0; bits[7:0] = 8'h5A;
    start_pkt(); send_bits(bits, 8, 1'b0);
    end_pkt(mk(2'b11, 4'b1010, 64'd0, 11'h0, 1'b0, 1'b0, 1'b0, 1'b0)); drain();

    // DATA0 while not expected
    receive_data = 1'b0;
    bits = data_pkt(8'hC3, pay);
    start_pkt(); send_bits(bits, 88, 1'b0);
    end_pkt(mk(2'b00, 4'b0011, 64'd0, 11'h0, 1'b1, 1'b0, 1'b0, 1'b0)); drain();
    receive_data = 1'b1;

    // EOP inside the PID byte
    bits = '0; bits[7:0] = 8'hD2;
    start_pkt(); send_bits(bits, 4, 1'b0);
    end_pkt(mk(2'b00, 4'b0000, 64'd0, 11'h0, 1'b0, 1'b0, 1'b1, 1'b0)); drain();

    // IN token, addr 5 endp 1
    bits = tok_pkt(8'h69, 11'h085);
    start_pkt(); send_bits(bits, 24, 1'b0);
`ifdef RC_TOKEN_RX_EN
    end_pkt(mk(2'b01, 4'b1001, 64'd0, 11'h085, 1'b0, 1'b0, 1'b0, 1'b0)); drain();
`else
    end_pkt(mk(2'b00, 4'b1001, 64'd0, 11'h000, 1'b1, 1'b0, 1'b0, 1'b0)); drain();
`endif

    check("idle_busy", 64'(busy), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
